vga_fb_scheduler: RTL and testbench
===================================

# vga_fb_scheduler

Schedules a single-port frame-buffer SRAM between display refresh and a pixel writer. Prefetches the visible frame in raster order into a small FIFO that feeds the pixel pipeline alongside `vga_sync` timing, and grants the remaining SRAM cycles to a valid/ready write port. Sits between `vga_sync`/pixel output logic and the SRAM interface.

## Interface
- `H_VISIBLE`, 640: visible pixels per line
- `V_VISIBLE`, 480: visible lines per frame
- `ADDR_BITS`, 19: SRAM address width; must satisfy 2^ADDR_BITS >= H_VISIBLE*V_VISIBLE
- `DATA_BITS`, 12: pixel/SRAM data width
- `FIFO_DEPTH`, 16: prefetch FIFO entries (power of two)
- `RD_LATENCY`, 2: cycles from registered read address to `sram_rdata` valid (>=1)
- `LOW_WATER`, 4: occupancy+in-flight below which reads take priority (< FIFO_DEPTH)

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-low
- `frame_start`  in  1  one-cycle pulse at start of vertical blanking; restarts prefetch at pixel 0
- `pix_ready`  in  1  consumer pops one pixel (asserted while `visible`)
- `pix_valid`  out  1  FIFO non-empty
- `pix_data`  out  DATA_BITS  FIFO head
- `underrun`  out  1  sticky: `pix_ready` seen while FIFO empty in FETCH/DONE
- `wr_valid`  in  1  writer request
- `wr_ready`  out  1  write granted this cycle (combinational)
- `wr_addr`  in  ADDR_BITS  write address
- `wr_data`  in  DATA_BITS  write data
- `sram_addr`  out  ADDR_BITS  registered address
- `sram_we`  out  1  registered write enable, active-high
- `sram_wdata`  out  DATA_BITS  registered write data
- `sram_rdata`  in  DATA_BITS  read data

## Operation
- States: IDLE (after reset), FETCH (reading frame), DONE (all H_VISIBLE*V_VISIBLE pixels issued).
- IDLE: no reads; writer granted every cycle `wr_valid`=1. `frame_start` -> FETCH.
- FETCH: per cycle, let `level` = FIFO occupancy + reads in flight.
  - `level < LOW_WATER`: read issued; `wr_ready`=0.
  - else `wr_valid`=1: write granted.
  - else `level < FIFO_DEPTH`: read issued.
  - else idle cycle (`sram_we`=0, address held).
- Each read increments the fetch address; the read that issues address H_VISIBLE*V_VISIBLE-1 moves to DONE.
- DONE: writer granted every cycle; FIFO drains; in-flight reads still land.
- `frame_start` in any state: FIFO flushed, in-flight reads discarded (pipeline valid bits cleared), fetch address = 0, -> FETCH. A write granted in the same cycle completes; no read issues that cycle.
- `level` never exceeds FIFO_DEPTH; the FIFO never overflows.
- Pop when `pix_ready` && `pix_valid`. Push and pop may occur in the same cycle.
- `pix_ready` with empty FIFO in FETCH/DONE: `underrun` set; no pop; `pix_data` undefined. Cleared only by reset. Ignored in IDLE.

## Timing
- Decision in cycle t; `sram_addr`/`sram_we`/`sram_wdata` registered, valid in t+1.
- Read data sampled at t+1+RD_LATENCY and pushed that cycle. Visible at `pix_data` the next cycle.
- `wr_ready` is combinational in cycle t. Handshake completes when `wr_valid`&&`wr_ready`. Writer holds `wr_addr`/`wr_data` until accepted.
- Read after write and write after read are back-to-back, with no turnaround cycle.
- Reset (`reset`=0 at edge) values: state IDLE, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0, `pix_valid`=0, `pix_data`=0, `underrun`=0, FIFO empty, in-flight cleared, fetch address 0.
- `wr_ready`=0 while `reset`=0.
- Reset mid-frame aborts all activity; reads returning afterwards are dropped.

## Test plan
- Reset, `frame_start`, `pix_ready`=0, `wr_valid`=0 (RD_LATENCY=2):
  - Reads issue on addresses 0..15, then stall.
  - `pix_valid` rises 4 cycles after the first read decision.
  - FIFO holds SRAM contents of 0..15.
- Writer saturating (`wr_valid`=1), consumer popping every cycle:
  - Reads win whenever `level` < 4; writes fill the remaining cycles.
  - Writes are accepted in order; `underrun` stays 0 with H_VISIBLE=8, V_VISIBLE=4.
- Full frame, 8x4 mode:
  - Exactly 32 reads, then DONE.
  - `wr_ready`=1 every subsequent cycle with `wr_valid`=1.
  - Popped data equals a model of SRAM.
- `frame_start` while 2 reads are in flight and FIFO holds 5:
  - Next cycle `pix_valid`=0.
  - Returning stale data is not pushed.
  - The first pushed word is address 0.
- Consumer pops with FIFO empty:
  - `underrun`=1 and stays 1 across `frame_start`; clears only on `reset`=0.
- `reset`=0 for one cycle mid-FETCH with writer pending:
  - All outputs return to reset values.
  - State IDLE; next cycle the writer is granted.

Source files
------------

// File: rtl/vga_fb_scheduler_if.sv
// Bundle of the frame-buffer scheduler's handshake and SRAM bus signals.
// slave  : the scheduler side.
// master : the environment side (display pipeline, pixel writer, SRAM).
interface vga_fb_scheduler_if #(
  parameter int ADDR_BITS = 19,
  parameter int DATA_BITS = 12
);
  // Display side: frame_start pulse and the prefetch FIFO pop port.
  logic                 frame_start;
  logic                 pix_ready;
  logic                 pix_valid;
  logic [DATA_BITS-1:0] pix_data;
  logic                 underrun;

  // Valid/ready rules for the write port:
  // - A transfer happens on a rising edge where wr_valid && wr_ready.
  // - The writer holds wr_addr/wr_data stable until that transfer.
  // - wr_ready is combinational and may depend on wr_valid.
  // - pix_valid/pix_ready follow the same transfer rule.
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;

  // Single-port SRAM: registered address, write enable and write data.
  logic [ADDR_BITS-1:0] sram_addr;
  logic                 sram_we;
  logic [DATA_BITS-1:0] sram_wdata;
  logic [DATA_BITS-1:0] sram_rdata;

  modport slave (
    input  frame_start, pix_ready, wr_valid, wr_addr, wr_data, sram_rdata,
    output pix_valid, pix_data, underrun, wr_ready, sram_addr, sram_we, sram_wdata
  );

  modport master (
    output frame_start, pix_ready, wr_valid, wr_addr, wr_data, sram_rdata,
    input  pix_valid, pix_data, underrun, wr_ready, sram_addr, sram_we, sram_wdata
  );
endinterface

// File: rtl/vga_fb_scheduler.sv
// Frame-buffer SRAM scheduler.
// Prefetches the visible frame in raster order into a small FIFO for the
// display. Every SRAM cycle the prefetch does not need goes to the pixel
// writer. FIFO fill level plus reads still in flight decides who wins.
module vga_fb_scheduler #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int ADDR_BITS  = 19,
  parameter int DATA_BITS  = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int LOW_WATER  = 4
) (
  input  logic                clk,
  input  logic                reset,
  vga_fb_scheduler_if.slave   bus,
  output logic [1:0]          dbg_state_o
);
  localparam int TOTAL = H_VISIBLE * V_VISIBLE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(TOTAL - 1);
  localparam logic [LVL_W-1:0]     LOW_LVL   = LVL_W'(LOW_WATER);
  localparam logic [LVL_W-1:0]     FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   fetch_addr_q, fetch_addr_d;
  logic [ADDR_BITS-1:0]   sram_addr_q, sram_addr_d;
  logic                   sram_we_q, sram_we_d;
  logic [DATA_BITS-1:0]   sram_wdata_q, sram_wdata_d;

  // Bit k of rd_pipe_q marks a read whose address went out k cycles ago.
  // The top bit lines up with sram_rdata carrying that read's data.
  logic [RD_LATENCY:0]    rd_pipe_q;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   underrun_q;

  logic                   wr_grant, rd_issue, flush, push, pop;
  logic [LVL_W-1:0]       inflight, level;

  // Level counts reads in flight as well as stored words.
  // A read is only issued when its data is guaranteed a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) begin
      inflight = inflight + LVL_W'(rd_pipe_q[i]);
    end
    level = LVL_W'(count_q) + inflight;
  end

  // Arbitration and next-state: pick read, write or idle for the SRAM slot.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    sram_addr_d  = sram_addr_q;
    sram_we_d    = 1'b0;
    sram_wdata_d = sram_wdata_q;
    wr_grant     = 1'b0;
    rd_issue     = 1'b0;
    flush        = 1'b0;

    case (state_q)
      S_IDLE: wr_grant = 1'b1;
      S_FETCH: begin
        if (level < LOW_LVL)          rd_issue = 1'b1;
        else if (bus.wr_valid)        wr_grant = 1'b1;
        else if (level < FULL_LVL)    rd_issue = 1'b1;
      end
      S_DONE: wr_grant = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (!reset) begin
      wr_grant = 1'b0;
      rd_issue = 1'b0;
    end

    // Restarting a frame never issues a read in the same cycle.
    // A write granted in that cycle still goes ahead.
    if (bus.frame_start) begin
      rd_issue     = 1'b0;
      flush        = 1'b1;
      state_d      = S_FETCH;
      fetch_addr_d = '0;
    end

    if (wr_grant && bus.wr_valid) begin
      sram_addr_d  = bus.wr_addr;
      sram_we_d    = 1'b1;
      sram_wdata_d = bus.wr_data;
    end else if (rd_issue) begin
      sram_addr_d  = fetch_addr_q;
      fetch_addr_d = fetch_addr_q + 1'b1;
      if (fetch_addr_q == LAST_ADDR) state_d = S_DONE;
    end
  end

  // FSM state, fetch pointer and the registered SRAM command.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      sram_addr_q  <= '0;
      sram_we_q    <= 1'b0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      sram_addr_q  <= sram_addr_d;
      sram_we_q    <= sram_we_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign push = rd_pipe_q[RD_LATENCY] && !flush;
  assign pop  = bus.pix_ready && (count_q != '0);

  // Read-return tracking and FIFO pointers.
  // A flush drops stored words and in-flight reads together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pipe_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else if (flush) begin
      rd_pipe_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rd_pipe_q <= {rd_pipe_q[RD_LATENCY-1:0], rd_issue};
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage.
  // It is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.sram_rdata;
    end
  end

  // Sticky underrun: consumer asked for a pixel the FIFO could not supply.
  always_ff @(posedge clk) begin
    if (!reset) begin
      underrun_q <= 1'b0;
    end else if (bus.pix_ready && (count_q == '0) && (state_q != S_IDLE)) begin
      underrun_q <= 1'b1;
    end
  end

  assign bus.pix_valid  = (count_q != '0);
  assign bus.pix_data   = mem_q[rd_ptr_q];
  assign bus.underrun   = underrun_q;
  assign bus.wr_ready   = wr_grant;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Testbench for vga_fb_scheduler in 8x4 mode.
// An SRAM model and randomised pixel writer run alongside a random consumer.
// A scoreboard checks popped pixels and SRAM write cycles.
module tb_vga_fb_scheduler;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int AB   = 6;
  localparam int DB   = 12;
  localparam int FD   = 16;
  localparam int RL   = 2;
  localparam int LW   = 4;
  localparam int NPIX = H * V;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_fb_scheduler_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();
  logic [1:0] dbg_state;

  vga_fb_scheduler #(
    .H_VISIBLE(H), .V_VISIBLE(V), .ADDR_BITS(AB), .DATA_BITS(DB),
    .FIFO_DEPTH(FD), .RD_LATENCY(RL), .LOW_WATER(LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cons_mode = 0;
  bit bg_en   = 1'b0;
  bit wr_busy = 1'b0;

  logic [DB-1:0]    ref_mem [64];
  bit               written [64];
  logic [DB-1:0]    exp_q[$];
  logic [AB+DB-1:0] wexp_q[$];
  logic [AB+DB-1:0] wr_req_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model: read data two cycles after the address ----------------
  logic [DB-1:0] sram_mem [64];
  logic [DB-1:0] rd_stage;
  always @(posedge clk) begin
    if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
    rd_stage       <= sram_mem[bus.sram_addr];
    bus.sram_rdata <= rd_stage;
  end

  // ---------------- consumer driver ----------------
  initial begin
    bus.pix_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (cons_mode)
        1:       bus.pix_ready = bus.pix_valid;
        2:       bus.pix_ready = bus.pix_valid && ($urandom_range(0, 3) != 0);
        3:       bus.pix_ready = 1'b1;
        default: bus.pix_ready = 1'b0;
      endcase
    end
  end

  // ---------------- writer driver (queued requests, else random background) ----------------
  initial begin
    logic [AB+DB-1:0] req;
    bit have;
    bit acc;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    forever begin
      @(posedge clk); #1;
      have = 1'b0;
      if (wr_req_q.size() != 0) begin
        req  = wr_req_q.pop_front();
        have = 1'b1;
      end else if (bg_en && ($urandom_range(0, 3) != 0)) begin
        req  = {AB'($urandom_range(32, 63)), DB'($urandom)};
        have = 1'b1;
      end
      if (!have) begin
        bus.wr_valid = 1'b0;
        wr_busy      = 1'b0;
      end else begin
        wr_busy      = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = req[AB+DB-1:DB];
        bus.wr_data  = req[DB-1:0];
        acc = 1'b0;
        for (int k = 0; k < 500; k++) begin
          @(negedge clk);
          if (reset && bus.wr_ready) begin
            acc = 1'b1;
            break;
          end
          @(posedge clk); #1;
        end
        if (acc) begin
          ref_mem[req[AB+DB-1:DB]] = req[DB-1:0];
          written[req[AB+DB-1:DB]] = 1'b1;
          wexp_q.push_back(req);
        end else begin
          check("wr_accept_timeout", 32'd0, 32'd1);
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [DB-1:0]    e;
    logic [AB+DB-1:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.pix_valid && bus.pix_ready) begin
          if (exp_q.size() == 0) begin
            check("pix_unexpected", 32'(bus.pix_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("pix_data", 32'(bus.pix_data), 32'(e));
          end
        end
        if (bus.sram_we) begin
          if (wexp_q.size() == 0) begin
            check("sram_write_unexpected", 32'(bus.sram_addr), 32'hFFFF_FFFF);
          end else begin
            w = wexp_q.pop_front();
            check("sram_write", 32'({bus.sram_addr, bus.sram_wdata}), 32'(w));
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_frame_start();
    @(posedge clk); #1;
    cons_mode       = 0;
    bus.frame_start = 1'b1;
    exp_q.delete();
    for (int a = 0; a < NPIX; a++) exp_q.push_back(ref_mem[a]);
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_writer(int limit);
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #3;
      if (wr_req_q.size() == 0 && !wr_busy) return;
    end
    check("writer_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    check("frame_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_sram_we"},    32'(bus.sram_we),    32'd0);
    check({tag, "_sram_addr"},  32'(bus.sram_addr),  32'd0);
    check({tag, "_sram_wdata"}, 32'(bus.sram_wdata), 32'd0);
    check({tag, "_pix_valid"},  32'(bus.pix_valid),  32'd0);
    check({tag, "_pix_data"},   32'(bus.pix_data),   32'd0);
    check({tag, "_underrun"},   32'(bus.underrun),   32'd0);
    check({tag, "_state"},      32'(dbg_state),      32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");

    // Consumer demand while idle must not flag an underrun.
    cons_mode = 3;
    repeat (4) @(negedge clk);
    check("idle_underrun_ignored", 32'(bus.underrun), 32'd0);
    cons_mode = 0;

    // Load a random image into the frame plus a few off-frame words.
    for (int a = 0; a < NPIX; a++) wr_req_q.push_back({AB'(a), DB'($urandom)});
    for (int a = 0; a < 4; a++) wr_req_q.push_back({AB'($urandom_range(32, 63)), DB'($urandom)});
    wait_writer(1000);

    // Prefetch with no consumer: first word after 4 cycles, stall at 16 reads.
    do_frame_start();
    n = 1;
    while (!bus.pix_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_pix_latency", 32'(n), 32'd5);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("stall_addr", 32'(bus.sram_addr), 32'd15);
    check("stall_we", 32'(bus.sram_we), 32'd0);
    check("stall_state", 32'(dbg_state), 32'd1);
    cons_mode = 1;
    wait_drain(500);
    check("frame_done_state", 32'(dbg_state), 32'd2);

    // Saturating writer with a consumer popping whenever data is there.
    bg_en = 1'b1;
    do_frame_start();
    cons_mode = 1;
    wait_drain(2000);
    check("sat_underrun", 32'(bus.underrun), 32'd0);
    check("sat_done_state", 32'(dbg_state), 32'd2);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.wr_valid) check("done_wr_ready", 32'(bus.wr_ready), 32'd1);
    end

    // Random consumer and writer for a full frame.
    do_frame_start();
    cons_mode = 2;
    wait_drain(3000);
    bg_en = 1'b0;
    wait_writer(1000);

    // Restart while words are stored and reads are in flight.
    do_frame_start();
    repeat (8) @(posedge clk);
    #1;
    check("pre_flush_valid", 32'(bus.pix_valid), 32'd1);
    do_frame_start();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("flush_empty", 32'(bus.pix_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("flush_refill", 32'(bus.pix_valid), 32'd1);
    cons_mode = 1;
    wait_drain(500);

    // Consumer pops an empty FIFO: underrun sets and survives frame_start.
    do_frame_start();
    cons_mode = 3;
    @(negedge clk);
    @(negedge clk);
    check("underrun_set", 32'(bus.underrun), 32'd1);
    wait_drain(500);
    do_frame_start();
    @(negedge clk);
    check("underrun_sticky", 32'(bus.underrun), 32'd1);

    // One-cycle reset mid-fetch with a write waiting behind the reads.
    wr_req_q.push_back({AB'(40), DB'($urandom)});
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_wr_grant", 32'(bus.wr_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(bus.pix_valid), 32'd0);
    end
    wait_writer(200);
    repeat (3) @(posedge clk);
    #1;
    check("pix_queue_empty", 32'(exp_q.size()), 32'd0);
    check("write_queue_empty", 32'(wexp_q.size()), 32'd0);
    for (int a = 0; a < 64; a++) begin
      if (written[a]) check("sram_contents", 32'(sram_mem[a]), 32'(ref_mem[a]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a bounded wait above is somehow bypassed.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
